// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: funct3 width codes, FSM states
// and the timeout counter width helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic int cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-aligned req/ack data-memory port; master side issues requests.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Extracts the addressed byte/half from a raw read word and sign/zero-extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(rdata >> {off, 3'b000});
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'b0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'b0, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-access front end: formats execute-stage loads/stores onto a req/ack port,
// stalls the pipeline until ack, and pulses fault on bad or timed-out accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [2:0]          ex_funct3,
  input  logic [31:0]         ex_addr,
  input  logic [31:0]         ex_store_data,
  mem_access_unit_if.master   mem,
  output logic [31:0]         load_data,
  output logic                stall,
  output logic                fault
);
  localparam int CNT_W = cnt_w(TIMEOUT_CYC);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]         be_q, be_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;

  logic [1:0]  off;
  logic        legal, misal, start, bad, timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, fmt;

  assign off = ex_addr[1:0];

  always_comb begin
    legal = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
            (ex_mem_read && ((ex_funct3 == F3_BU) || (ex_funct3 == F3_HU)));
    misal = ((ex_funct3[1:0] == 2'b01) && off[0]) ||
            ((ex_funct3[1:0] == 2'b10) && (off != 2'b00));
  end

  assign start   = (state_q == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
  assign bad     = !legal || misal || (ex_mem_read && ex_mem_write);
  assign timeout = (state_q == BUSY) && !mem.mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Loads request the full word; the formatter picks the lane on the way back.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << off;
          st_wdata = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << off;
          st_wdata = {2{ex_store_data[15:0]}};
        end
        default: st_wdata = ex_store_data;
      endcase
    end
  end

  load_formatter u_fmt (
    .rdata  (mem.mem_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .data   (fmt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad) begin
            fault = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = {ex_addr[31:2], 2'b00};
            wdata_d = st_wdata;
            be_d    = st_be;
            f3_d    = ex_funct3;
            off_d   = off;
          end
        end
      end
      BUSY: begin
        // Ack beats an expiring counter in the same cycle.
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) load_d = fmt;
        end else if (timeout) begin
          fault   = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign load_data = ((state_q == BUSY) && mem.mem_ack && !we_q) ? fmt : load_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random accesses against a byte-level model.
module tb_mem_access_unit;
  logic        clk = 0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic        ack, sel;
  logic [31:0] rdata;
  logic [31:0] load_a, load_b;
  logic        stall_a, stall_b, fault_a, fault_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] lq [2];

  always #5 clk = ~clk;

  mem_access_unit_if mi_a ();
  mem_access_unit_if mi_b ();
  assign mi_a.mem_ack   = ack & ~sel;
  assign mi_b.mem_ack   = ack & sel;
  assign mi_a.mem_rdata = rdata;
  assign mi_b.mem_rdata = rdata;

  mem_access_unit dut_a (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .mem(mi_a.master), .load_data(load_a),
    .stall(stall_a), .fault(fault_a));

  mem_access_unit #(.TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .mem(mi_b.master), .load_data(load_b),
    .stall(stall_b), .fault(fault_b));

  logic        o_req, o_we, o_stall, o_fault;
  logic [31:0] o_addr, o_wdata, o_load;
  logic [3:0]  o_be;
  always_comb begin
    o_req   = sel ? mi_b.mem_req   : mi_a.mem_req;
    o_we    = sel ? mi_b.mem_we    : mi_a.mem_we;
    o_addr  = sel ? mi_b.mem_addr  : mi_a.mem_addr;
    o_wdata = sel ? mi_b.mem_wdata : mi_a.mem_wdata;
    o_be    = sel ? mi_b.mem_be    : mi_a.mem_be;
    o_stall = sel ? stall_b : stall_a;
    o_fault = sel ? fault_b : fault_a;
    o_load  = sel ? load_b  : load_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes and byte-lane arithmetic.
  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_bad(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    return (r && w) || !legal || ((a % sz(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input bit r, input logic [2:0] f3, input logic [31:0] a);
    int v;
    if (r) return 4'hF;
    v = ((1 << sz(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input bit r, input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] v;
    v = 0;
    if (r) return 0;
    for (int k = 0; k < 4; k++)
      v = v | (((sd >> (8 * (k % sz(f3)))) & 32'hFF) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint mask, v;
    int n;
    n = sz(f3);
    mask = (64'd1 << (8 * n)) - 1;
    v = longint'(rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic garble();
    ex_valid = 1'($urandom); ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
    ex_funct3 = 3'($urandom); ex_addr = $urandom; ex_store_data = $urandom;
  endtask

  // Entered and left just after a rising edge.
  task automatic do_access(input bit s, input bit v, input bit r, input bit w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int dly);
    bit st, bd;
    logic [31:0] exp_ld;
    sel = s; ack = 0;
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3; ex_addr = a; ex_store_data = sd;
    st = v && (r || w);
    bd = st && m_bad(r, w, f3, a);
    @(negedge clk);
    chk("start_fault", o_fault, 32'(bd));
    chk("start_stall", o_stall, 32'(st && !bd));
    @(posedge clk); #1;
    if (!st || bd) begin
      ex_valid = 0;
      @(negedge clk);
      chk("idle_req", o_req, 0);
      chk("idle_stall", o_stall, 0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < dly; i++) begin
      garble();
      @(negedge clk);
      chk("busy_req", o_req, 1);
      chk("busy_we", o_we, 32'(w));
      chk("busy_addr", o_addr, a & ~32'd3);
      chk("busy_be", o_be, m_be(r, f3, a));
      chk("busy_wdata", o_wdata, m_wdata(r, f3, sd));
      chk("busy_stall", o_stall, 1);
      chk("busy_fault", o_fault, 0);
      @(posedge clk); #1;
    end
    garble();
    ack = 1; rdata = rd;
    exp_ld = r ? m_load(f3, a, rd) : lq[s];
    @(negedge clk);
    chk("ack_req", o_req, 1);
    chk("ack_addr", o_addr, a & ~32'd3);
    chk("ack_be", o_be, m_be(r, f3, a));
    chk("ack_wdata", o_wdata, m_wdata(r, f3, sd));
    chk("ack_stall", o_stall, 0);
    chk("ack_fault", o_fault, 0);
    chk("ack_load", o_load, exp_ld);
    lq[s] = exp_ld;
    @(posedge clk); #1;
    ack = 0; ex_valid = 0; rdata = $urandom;
    @(negedge clk);
    chk("done_req", o_req, 0);
    chk("done_stall", o_stall, 0);
    chk("done_load", o_load, lq[s]);
    @(posedge clk); #1;
  endtask

  initial begin
    sel = 0; ack = 0; rdata = 0; reset = 1;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0; ex_addr = 0; ex_store_data = 0;
    lq[0] = 0; lq[1] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req", o_req, 0);
    chk("rst_be", o_be, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_load", o_load, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_fault", o_fault, 0);
    @(posedge clk); #1;

    do_access(0, 1, 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    do_access(0, 1, 1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0);
    chk("lb_const", lq[0], 32'hFFFFFF80);
    do_access(0, 1, 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1);
    chk("lbu_const", lq[0], 32'h00000080);
    do_access(0, 1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 4);
    do_access(0, 1, 1, 0, 3'b010, 32'h101, 0, 0, 0);
    do_access(0, 1, 0, 1, 3'b001, 32'h003, 0, 0, 0);
    do_access(0, 1, 1, 0, 3'b011, 32'h100, 0, 0, 0);
    do_access(0, 1, 1, 1, 3'b010, 32'h100, 0, 0, 0);

    for (int n = 0; n < 60; n++)
      do_access(0, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                $urandom, $urandom, $urandom, $urandom_range(0, 3));

    // Timeout instance: ack on the expiry cycle, then a real timeout.
    reset = 1; @(posedge clk); #1 reset = 0;
    lq[0] = 0; lq[1] = 0;
    do_access(1, 1, 1, 0, 3'b010, 32'h40, 0, 32'hCAFEF00D, 3);
    sel = 1; ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010; ex_addr = 32'h80;
    @(negedge clk);
    chk("to_start_stall", o_stall, 1);
    @(posedge clk); #1 ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_wait_stall", o_stall, 1);
      chk("to_wait_fault", o_fault, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_fault", o_fault, 1);
    chk("to_stall", o_stall, 0);
    chk("to_req_hi", o_req, 1);
    chk("to_load", o_load, lq[1]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_req_lo", o_req, 0);
    chk("to_fault_lo", o_fault, 0);
    chk("to_load_kept", o_load, lq[1]);
    @(posedge clk); #1;
    do_access(1, 1, 1, 0, 3'b101, 32'h2, 0, 32'h9ABC1234, 0);

    // Reset in the second BUSY cycle.
    sel = 0; ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010; ex_addr = 32'h300;
    @(posedge clk); #1 ex_valid = 0;
    @(negedge clk);
    chk("rb_req1", o_req, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    lq[0] = 0; lq[1] = 0;
    @(negedge clk);
    chk("rb_req", o_req, 0);
    chk("rb_we", o_we, 0);
    chk("rb_addr", o_addr, 0);
    chk("rb_wdata", o_wdata, 0);
    chk("rb_be", o_be, 0);
    chk("rb_load", o_load, 0);
    chk("rb_stall", o_stall, 0);
    chk("rb_fault", o_fault, 0);
    @(posedge clk); #1 ack = 1; rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("late_ack_stall", o_stall, 0);
    chk("late_ack_load", o_load, 0);
    @(posedge clk); #1 ack = 0;
    @(negedge clk);
    chk("late_ack_req", o_req, 0);
    chk("late_ack_load2", o_load, 0);
    @(posedge clk); #1;
    do_access(0, 1, 1, 0, 3'b010, 32'h304, 0, 32'h0BADF00D, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
